// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment order is {A,B,C,D,E,F,G}, A in the MSB.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1110011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-decimal nibbles render as a dark digit.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    // Table lookup; anything above 9 stays dark.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with leading-zero
// blanking, per-digit blink and selectable output polarity.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_SCANS    = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*N_DIGITS-1:0]     value,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [N_DIGITS-1:0]       blink_mask,
    output logic [6:0]                seg,
    output logic [N_DIGITS-1:0]       digit_sel
);

    localparam int VAL_W = BCD_W * N_DIGITS;
    localparam int PRE_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = cnt_width(N_DIGITS);
    localparam int BLK_W = cnt_width(BLINK_SCANS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SCANS - 1);

    // XOR masks: also the "everything off" pattern after inversion.
    localparam logic [SEG_W-1:0]    SEG_INV =
        (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_DIGITS-1:0] SEL_INV =
        (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [VAL_W-1:0]    shadow_q, shadow_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;

    logic                pre_tc;
    logic                scan_wrap;
    logic [VAL_W-1:0]    shifted;
    logic [BCD_W-1:0]    nibble;
    logic                lz_blank;
    logic                blink_off;
    logic [SEG_W-1:0]    seg_raw;
    logic [SEG_W-1:0]    seg_vis;
    logic [N_DIGITS-1:0] sel_oh;

    // Shadow register holds the displayed word between loads.
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = value;
        end
    end

    // Slot prescaler and digit index; a full-scan wrap is flagged.
    always_comb begin
        pre_d     = pre_q + PRE_W'(1);
        idx_d     = idx_q;
        pre_tc    = (pre_q == PRE_LAST);
        scan_wrap = 1'b0;
        if (pre_tc) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d     = '0;
                scan_wrap = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Blink half-period counted in full scan rounds.
    always_comb begin
        blk_cnt_d     = blk_cnt_q;
        blink_phase_d = blink_phase_q;
        if (scan_wrap) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d     = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    // Current nibble, plus "this and all higher nibbles are zero".
    always_comb begin
        shifted   = shadow_q >> {idx_q, 2'b00};
        nibble    = shifted[BCD_W-1:0];
        lz_blank  = blank_lz && (idx_q != '0) && (shifted == '0);
        blink_off = blink_phase_q && blink_mask[idx_q];
    end

    bcd_to_seg7 u_dec (
        .bcd (nibble),
        .seg (seg_raw)
    );

    // Blanked digits stay selected so every slot has equal duty.
    always_comb begin
        seg_vis = seg_raw;
        if (lz_blank || blink_off) begin
            seg_vis = SEG_BLANK;
        end
        seg_d = seg_vis ^ SEG_INV;
    end

    // One-hot select decoded from the index, then polarity applied.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            sel_oh[i] = (idx_q == IDX_W'(i));
        end
        sel_d = sel_oh ^ SEL_INV;
    end

    // All state; reset drops the scan mid-slot with outputs dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            pre_q         <= '0;
            idx_q         <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_INV;
            sel_q         <= SEL_INV;
        end else begin
            shadow_q      <= shadow_d;
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            sel_q         <= sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: one active-high instance, one fully inverted.
// Edge counts below are edges since the last reset release.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  digit_sel;

    logic        rst_i;
    logic [15:0] value_i;
    logic        load_i;
    logic [6:0]  seg_i;
    logic [3:0]  sel_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (4),
        .BLINK_SCANS    (2),
        .SEG_ACTIVE_LOW (0),
        .SEL_ACTIVE_LOW (0)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .seg        (seg),
        .digit_sel  (digit_sel)
    );

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (4),
        .BLINK_SCANS    (2),
        .SEG_ACTIVE_LOW (1),
        .SEL_ACTIVE_LOW (1)
    ) u_inv (
        .clk        (clk),
        .reset      (rst_i),
        .value      (value_i),
        .load       (load_i),
        .blank_lz   (1'b0),
        .blink_mask (4'b0000),
        .seg        (seg_i),
        .digit_sel  (sel_i)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic [6:0] s_exp,
                           input logic [3:0] d_exp);
        chk({tag, ".seg"}, {9'd0, seg}, {9'd0, s_exp});
        chk({tag, ".sel"}, {12'd0, digit_sel}, {12'd0, d_exp});
    endtask

    task automatic chk_inv(input string tag,
                           input logic [6:0] s_exp,
                           input logic [3:0] d_exp);
        chk({tag, ".seg"}, {9'd0, seg_i}, {9'd0, s_exp});
        chk({tag, ".sel"}, {12'd0, sel_i}, {12'd0, d_exp});
    endtask

    initial begin
        reset      = 1'b1;
        rst_i      = 1'b1;
        value      = 16'h0000;
        load       = 1'b0;
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        value_i    = 16'h0000;
        load_i     = 1'b0;

        // reset held three cycles
        step(3);
        chk_out("rst", 7'b0000000, 4'b0000);
        chk_inv("rst_inv", 7'b1111111, 4'b1111);

        reset = 1'b0;
        rst_i = 1'b0;
        step(1);
        chk_out("rel", 7'b1111110, 4'b0001);

        // 0x1234, loaded at edge 2, visible from edge 3
        value = 16'h1234;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        step(1);
        chk_out("d0_start", 7'b0110011, 4'b0001);
        step(1);
        chk_out("d0_end", 7'b0110011, 4'b0001);
        step(1);
        chk_out("d1_start", 7'b1111001, 4'b0010);
        step(3);
        chk_out("d1_end", 7'b1111001, 4'b0010);
        step(1);
        chk_out("d2_start", 7'b1101101, 4'b0100);
        step(3);
        chk_out("d2_end", 7'b1101101, 4'b0100);
        step(1);
        chk_out("d3_start", 7'b0110000, 4'b1000);
        step(3);
        chk_out("d3_end", 7'b0110000, 4'b1000);
        step(1);
        chk_out("wrap_d0", 7'b0110011, 4'b0001);

        // edge 17: 0x0070 with leading-zero blanking
        value    = 16'h0070;
        blank_lz = 1'b1;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        step(1);
        chk_out("lz70_d0", 7'b1111110, 4'b0001);
        step(2);
        chk_out("lz70_d1", 7'b1110000, 4'b0010);
        step(4);
        chk_out("lz70_d2", 7'b0000000, 4'b0100);
        step(4);
        chk_out("lz70_d3", 7'b0000000, 4'b1000);

        // edge 29: all-zero value keeps only digit 0 lit
        value = 16'h0000;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        step(3);
        chk_out("lz0_d0", 7'b1111110, 4'b0001);
        step(4);
        chk_out("lz0_d1", 7'b0000000, 4'b0010);
        step(8);
        chk_out("lz0_d3", 7'b0000000, 4'b1000);

        // edge 45: non-decimal nibble, blanking off
        value    = 16'h00A5;
        blank_lz = 1'b0;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        step(3);
        chk_out("a5_d0", 7'b1011011, 4'b0001);
        step(4);
        chk_out("a5_d1", 7'b0000000, 4'b0010);
        step(4);
        chk_out("a5_d2", 7'b1111110, 4'b0100);

        // edge 57: blink digit 0; phase is 0 for edges 65..96
        value      = 16'h0008;
        blink_mask = 4'b0001;
        load       = 1'b1;
        step(1);
        load       = 1'b0;
        step(7);
        chk_out("blk_on", 7'b1111111, 4'b0001);
        step(32);
        chk_out("blk_off", 7'b0000000, 4'b0001);
        step(3);
        chk_out("blk_off_end", 7'b0000000, 4'b0001);
        step(1);
        chk_out("blk_d1", 7'b1111110, 4'b0010);
        step(28);
        chk_out("blk_on2", 7'b1111111, 4'b0001);

        // edge 129 -> 138: mid-slot of digit 2
        step(9);
        chk_out("mid_d2", 7'b1111110, 4'b0100);
        reset = 1'b1;
        rst_i = 1'b1;
        step(1);
        chk_out("mid_rst", 7'b0000000, 4'b0000);
        chk_inv("mid_rst_inv", 7'b1111111, 4'b1111);

        reset = 1'b0;
        step(1);
        chk_out("restart_d0", 7'b1111110, 4'b0001);
        step(3);
        chk_out("restart_d0_end", 7'b1111110, 4'b0001);
        step(1);
        chk_out("restart_d1", 7'b1111110, 4'b0010);

        // inverted instance: 0x0042 loaded at its first edge
        rst_i   = 1'b0;
        value_i = 16'h0042;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
        chk_inv("inv_d0_old", 7'b0000001, 4'b1110);
        step(1);
        chk_inv("inv_d0", 7'b0010010, 4'b1110);
        step(3);
        chk_inv("inv_d1", 7'b1001100, 4'b1101);
        step(4);
        chk_inv("inv_d2", 7'b0000001, 4'b1011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
